// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift path: MIPS funct codes,
// shifter operation codes and the legality check used by the decoder.
package shift_pkg;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_SRAV = 6'h07;

   localparam logic [1:0] SH_SLL  = 2'b00;
   localparam logic [1:0] SH_SRL  = 2'b01;
   localparam logic [1:0] SH_SRA  = 2'b11;
   localparam logic [1:0] SH_NONE = 2'b10;

   function automatic logic is_legal_shift(input logic [5:0] funct);
      logic legal;
      case (funct)
         FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
         FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: legal = 1'b1;
         default:                             legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an R-type shift: shifter op code, shift amount
// (immediate shamt or low bits of rs) and whether the funct is a real shift.
module shift_decode
   import shift_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [4:0] rs_low,
   input  logic [4:0] shamt,
   output logic [1:0] code,
   output logic [4:0] n,
   output logic       legal
);

   logic variable_amt;

   // funct bits [1:0] are swapped so srl/sra land on codes 01/11.
   assign code         = {funct[0], funct[1]};
   assign variable_amt = funct[2];
   assign n            = variable_amt ? rs_low : shamt;
   assign legal        = is_legal_shift(funct);

endmodule

// File: rtl/shift_exec_stage.sv
// Two-register execute stage around an external shifter: S1 holds the decoded
// op driving the shifter, S2 captures its result for MEM. Valid/ready on both
// sides with stall and flush. Define SHIFT_ILLEGAL_TRAP_EN to add out_illegal.
module shift_exec_stage
   import shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_funct,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [4:0]        in_shamt,
   input  logic [REG_W-1:0]  in_rd,
   output logic [1:0]        sh_funct,
   output logic [DATA_W-1:0] sh_a,
   output logic [4:0]        sh_n,
   input  logic [DATA_W-1:0] sh_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wen
`ifdef SHIFT_ILLEGAL_TRAP_EN
   ,
   output logic              out_illegal
`endif
);

   logic             s1_valid;
   logic             s2_valid;
   logic [REG_W-1:0] s1_rd;
   logic             s1_legal;
   logic [1:0]       dec_code;
   logic [4:0]       dec_n;
   logic             dec_legal;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;
   logic             unused_rs_high;

   // Only the low five bits of rs can form a shift amount.
   assign unused_rs_high = ^in_rs[DATA_W-1:5];

   shift_decode u_decode (
      .funct  (in_funct),
      .rs_low (in_rs[4:0]),
      .shamt  (in_shamt),
      .code   (dec_code),
      .n      (dec_n),
      .legal  (dec_legal)
   );

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = s1_valid && s2_adv;
   assign in_ready  = !s1_valid || s2_adv;
   assign accept    = in_valid && in_ready && !flush;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         sh_funct <= SH_SLL;
         sh_a     <= '0;
         sh_n     <= '0;
         s1_rd    <= '0;
         s1_legal <= 1'b0;
      end else begin
         if (flush)       s1_valid <= 1'b0;
         else if (accept) s1_valid <= 1'b1;
         else if (s1_adv) s1_valid <= 1'b0;
         if (accept) begin
            sh_funct <= dec_code;
            sh_a     <= in_rt;
            sh_n     <= dec_n;
            s1_rd    <= in_rd;
            s1_legal <= dec_legal;
         end
      end
   end

   // Illegal ops produce a zero result regardless of what the shifter does
   // with the raw funct bits (e.g. 0x20 would otherwise decode as sll).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
         out_wen    <= 1'b0;
      end else begin
         if (flush)          s2_valid <= 1'b0;
         else if (s1_adv)    s2_valid <= 1'b1;
         else if (out_ready) s2_valid <= 1'b0;
         if (flush) begin
            out_wen <= 1'b0;
         end else if (s1_adv) begin
            out_result <= s1_legal ? sh_r : '0;
            out_rd     <= s1_rd;
            out_wen    <= s1_legal && (s1_rd != '0);
         end
      end
   end

`ifdef SHIFT_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       out_illegal <= 1'b0;
      else if (flush)  out_illegal <= 1'b0;
      else if (s1_adv) out_illegal <= !s1_legal;
   end
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage; models the external shifter and checks
// decode, latency, throughput, backpressure, flush and asynchronous reset.
module tb_shift_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [4:0]  in_shamt;
   logic [4:0]  in_rd;
   logic [1:0]  sh_funct;
   logic [31:0] sh_a;
   logic [4:0]  sh_n;
   logic [31:0] sh_r;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_wen;
`ifdef SHIFT_ILLEGAL_TRAP_EN
   logic        out_illegal;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // External combinational shifter.
   always_comb begin
      sh_r = '0;
      case (sh_funct)
         2'b00:   sh_r = sh_a << sh_n;
         2'b01:   sh_r = sh_a >> sh_n;
         2'b11:   sh_r = $unsigned($signed(sh_a) >>> sh_n);
         default: sh_r = '0;
      endcase
   end

   shift_exec_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_funct   (in_funct),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_shamt   (in_shamt),
      .in_rd      (in_rd),
      .sh_funct   (sh_funct),
      .sh_a       (sh_a),
      .sh_n       (sh_n),
      .sh_r       (sh_r),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd),
      .out_wen    (out_wen)
`ifdef SHIFT_ILLEGAL_TRAP_EN
      ,
      .out_illegal(out_illegal)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sa, input logic [4:0] rd);
      in_valid = 1'b1;
      in_funct = f;
      in_rs    = rs;
      in_rt    = rt;
      in_shamt = sa;
      in_rd    = rd;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_funct = '0; in_rs = '0; in_rt = '0; in_shamt = '0; in_rd = '0;
      step();
      step();
      reset = 1'b0;
      #1;
      total++;
      if ({out_valid, out_wen, out_result, out_rd} !== 39'd0) begin
         bad++;
         $display("FAIL reset_out: got valid=%b wen=%b res=%h rd=%0d want all 0",
                  out_valid, out_wen, out_result, out_rd);
      end
      total++;
      if ({sh_funct, sh_a, sh_n} !== 39'd0) begin
         bad++;
         $display("FAIL reset_sh: got funct=%b a=%h n=%0d want all 0", sh_funct, sh_a, sh_n);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   // Single op through the pipe: sh_* at t+1, out_* at t+2, gone at t+3.
   task automatic test_decode();
      logic [5:0]  v_f   [8] = '{6'h00, 6'h03, 6'h07, 6'h06, 6'h01, 6'h02, 6'h04, 6'h20};
      logic [31:0] v_rs  [8] = '{32'h0, 32'h0, 32'h20, 32'h24, 32'h0, 32'h0, 32'h1F, 32'h0};
      logic [31:0] v_rt  [8] = '{32'hF1, 32'h8000_0000, 32'h8000_0001, 32'hF000_0000,
                                 32'h1234, 32'h100, 32'h1, 32'h5};
      logic [4:0]  v_sa  [8] = '{5'd4, 5'd4, 5'd9, 5'd0, 5'd2, 5'd8, 5'd0, 5'd1};
      logic [4:0]  v_rd  [8] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0, 5'd31, 5'd9};
      logic [1:0]  e_cd  [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
      logic [4:0]  e_n   [8] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd2, 5'd8, 5'd31, 5'd1};
      logic [31:0] e_res [8] = '{32'h0000_0F10, 32'hF800_0000, 32'h8000_0001, 32'h0F00_0000,
                                 32'h0, 32'h1, 32'h8000_0000, 32'h0};
      logic        e_wen [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         out_ready = 1'b1;
         drive(v_f[i], v_rs[i], v_rt[i], v_sa[i], v_rd[i]);
         step();
         in_valid = 1'b0;
         total++;
         if (sh_funct !== e_cd[i] || sh_n !== e_n[i] || sh_a !== v_rt[i]) begin
            bad++;
            $display("FAIL decode_sh[%0d]: got funct=%b n=%0d a=%h want funct=%b n=%0d a=%h",
                     i, sh_funct, sh_n, sh_a, e_cd[i], e_n[i], v_rt[i]);
         end
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL decode_early[%0d]: got out_valid=%b want 0", i, out_valid);
         end
         step();
         total++;
         if (out_valid !== 1'b1 || out_result !== e_res[i] || out_rd !== v_rd[i] ||
             out_wen !== e_wen[i]) begin
            bad++;
            $display("FAIL decode_out[%0d]: got v=%b res=%h rd=%0d wen=%b want v=1 res=%h rd=%0d wen=%b",
                     i, out_valid, out_result, out_rd, out_wen, e_res[i], v_rd[i], e_wen[i]);
         end
`ifdef SHIFT_ILLEGAL_TRAP_EN
         total++;
         if (out_illegal !== (i == 4 || i == 7)) begin
            bad++;
            $display("FAIL decode_illegal[%0d]: got %b want %b", i, out_illegal, (i == 4 || i == 7));
         end
`endif
         $display("op funct=%h rt=%h -> res=%h rd=%0d wen=%b", v_f[i], v_rt[i], out_result, out_rd, out_wen);
         step();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL decode_drain[%0d]: got out_valid=%b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_throughput();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(6'h00, 32'h0, 32'h1, 5'(i + 1), 5'(11 + i));
         else       in_valid = 1'b0;
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL thru_ready[%0d]: got %b want 1", i, in_ready);
         end
         if (i >= 2) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== (32'h2 << (i - 2)) || out_rd !== 5'(9 + i)) begin
               bad++;
               $display("FAIL thru_out[%0d]: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d",
                        i, out_valid, out_result, out_rd, 32'h2 << (i - 2), 9 + i);
            end
            $display("thru cycle %0d: res=%h rd=%0d", i, out_result, out_rd);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got_res [$];
      logic [4:0]  got_rd  [$];
      out_ready = 1'b0;
      drive(6'h00, 32'h0, 32'h1, 5'd1, 5'd1);   // A -> 0x2
      step();
      drive(6'h00, 32'h0, 32'h1, 5'd2, 5'd2);   // B -> 0x4
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second_accept: got in_ready=%b want 1", in_ready);
      end
      step();
      drive(6'h00, 32'h0, 32'h1, 5'd3, 5'd3);   // C -> 0x8, blocked
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h2 || out_rd !== 5'd1) begin
            bad++;
            $display("FAIL b2b_stall[%0d]: got rdy=%b v=%b res=%h rd=%0d want rdy=0 v=1 res=2 rd=1",
                     c, in_ready, out_valid, out_result, out_rd);
         end
         $display("stall cycle %0d: in_ready=%b res=%h", c, in_ready, out_result);
         step();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_release: got in_ready=%b want 1", in_ready);
      end
      for (int c = 0; c < 8; c++) begin
         if (out_valid) begin
            got_res.push_back(out_result);
            got_rd.push_back(out_rd);
         end
         step();
         in_valid = 1'b0;
      end
      total++;
      if (got_res.size() != 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d results want 3", got_res.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (got_res[k] !== (32'h2 << k) || got_rd[k] !== 5'(k + 1)) begin
               bad++;
               $display("FAIL b2b_order[%0d]: got res=%h rd=%0d want res=%h rd=%0d",
                        k, got_res[k], got_rd[k], 32'h2 << k, k + 1);
            end
            $display("b2b result %0d: res=%h rd=%0d", k, got_res[k], got_rd[k]);
         end
      end
   endtask

   task automatic test_flush();
      int writes = 0;
      out_ready = 1'b0;
      drive(6'h00, 32'h0, 32'h3, 5'd1, 5'd9);
      step();
      drive(6'h00, 32'h0, 32'h3, 5'd2, 5'd10);
      step();
      drive(6'h00, 32'h0, 32'h3, 5'd3, 5'd12);
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL flush_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_clear: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      for (int c = 0; c < 4; c++) begin
         if (out_valid && out_wen) writes++;
         step();
      end
      total++;
      if (writes != 0) begin
         bad++;
         $display("FAIL flush_writes: got %0d writes want 0", writes);
      end
      $display("flush: out_valid=%b in_ready=%b writes=%0d", out_valid, in_ready, writes);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      drive(6'h00, 32'h0, 32'h3, 5'd1, 5'd4);
      step();
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h6 || out_wen !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre: got v=%b res=%h wen=%b want v=1 res=6 wen=1",
                  out_valid, out_result, out_wen);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_result !== 32'h0) begin
         bad++;
         $display("FAIL areset_now: got v=%b wen=%b res=%h want 0 0 0", out_valid, out_wen, out_result);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      drive(6'h00, 32'h0, 32'h1, 5'd5, 5'd2);
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL areset_lat1: got out_valid=%b want 0", out_valid);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h20 || out_rd !== 5'd2) begin
         bad++;
         $display("FAIL areset_lat2: got v=%b res=%h rd=%0d want v=1 res=20 rd=2",
                  out_valid, out_result, out_rd);
      end
      $display("after reset: res=%h rd=%0d", out_result, out_rd);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_throughput();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage wrapper that feeds the combinational shifter and registers its result for the MEM stage.
- Stage S1 (issue register): accepts decoded R-type shift ops from ID, then derives the shifter's 2-bit funct, operand a and amount N.
- Stage S2 (result register): captures shifter output R together with destination tag and write enable.
- Valid/ready handshake on both sides; supports stall and flush.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported)
- REG_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of both stages (branch/exception redirect)
- in_valid  in  1  ID has an op
- in_ready  out  1  stage can accept this cycle
- in_funct  in  6  MIPS R-type funct field
- in_rs  in  32  rs value (variable amount source)
- in_rt  in  32  rt value (data shifted)
- in_shamt  in  5  instruction shamt field
- in_rd  in  5  destination register
- sh_funct  out  2  to shifter: 00 sll, 01 srl, 11 sra, 10 unused
- sh_a  out  32  to shifter operand
- sh_n  out  5  to shifter amount
- sh_r  in  32  shifter result
- out_valid  out  1  result valid to MEM
- out_ready  in  1  MEM accepts
- out_result  out  32  registered shift result
- out_rd  out  5  destination register
- out_wen  out  1  register-file write enable

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_rd=0, out_wen=0. S1 data registers also clear, so sh_funct=00, sh_a=0, sh_n=0.
- Decode, at acceptance:
  - sh_funct = {funct[0], funct[1]}
  - variable = funct[2]
  - N = variable ? rs[4:0] : shamt
  - a = rt
  - Legal functs: 000000, 000010, 000011, 000100, 000110, 000111.
  - Any other funct (including 000001/000101, which map to code 10): treated as a NOP. Shifter outputs 0 and wen is forced 0.
- Occupancy states: EMPTY (no stage valid), ONE (exactly one valid), FULL (both valid); derived from s1_valid/s2_valid.
  - s2_adv = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv
  - There is no combinational path from in_valid to in_ready. A combinational path from out_ready to in_ready is permitted.
- Latency: an op accepted at the edge ending cycle t appears on sh_* in cycle t+1 and on out_* (out_valid=1) in cycle t+2. Throughput is 1/cycle with out_ready held high.
- S2 load (on s1_adv): out_result=sh_r, out_rd=rd, out_wen = legal && rd!=0.
- Backpressure: out_valid=1 && out_ready=0 holds out_* stable. S1 then holds; in_ready drops only once S1 is also full.
- Simultaneous accept and advance: S1 reloads in the same edge at which it hands off to S2.
- flush: at the next edge s1_valid=0 and s2_valid=0, and any input offered that cycle is dropped. flush overrides in_valid and out_ready. Data registers may keep stale values.
- Mid-operation reset: all valids clear immediately and asynchronously; no partial op survives.
- rd==0: op flows normally with out_wen=0.

Optional Feature:
- SHIFT_ILLEGAL_TRAP_EN defined:
  - Adds output out_illegal (1 bit), which is registered alongside out_result.
  - out_illegal=1 when the accepted funct is not a legal shift; it is reset/flushed to 0.
- Undefined: port absent; illegal functs are silent NOPs as above.

Decomposition:
- Shared package (shift_pkg):
  - funct constants: FUNCT_SLL=6'h00, SRL=6'h02, SRA=6'h03, SLLV=6'h04, SRLV=6'h06, SRAV=6'h07
  - shifter codes: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11, SH_NONE=2'b10
  - an is_legal_shift function
- One natural sub-module: shift_decode (combinational funct/rs/shamt -> sh_funct, N, legal).
- The shifter itself is instantiated at the top level, not inside this block.

Test Plan:
- sll shamt=4, rt=0x0000_00F1, rd=3, out_ready=1 -> cycle t+2: out_result=0x0000_0F10, out_rd=3, out_wen=1.
- sra shamt=4, rt=0x8000_0000 -> out_result=0xF800_0000. srav with rs=0x0000_0020 (N=0), rt=0x8000_0001 -> 0x8000_0001.
- srlv rs=0x0000_0024 (N=4), rt=0xF000_0000 -> 0x0F00_0000. funct=0x01 -> out_result=0, out_wen=0 (out_illegal=1 if SHIFT_ILLEGAL_TRAP_EN).
- Back-to-back 3 ops, out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - out_* stable while stalled.
  - All 3 results emerge in order once out_ready=1; none lost or duplicated.
- flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0 and in_ready=1; no write from the flushed ops.
- reset pulsed asynchronously mid-stream (between edges) -> out_valid, out_wen, out_result go 0 immediately; first op after release has normal 2-cycle latency.
